imem_loader: RTL and testbench

Program loader that writes into the fetch-stage instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit MIPS words. It issues one write per word to the instruction memory write port and holds the CPU (PC enable low, pipeline in reset) until the image is verified. It is the writer counterpart of the read-only instruction fetch path.

---
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction-memory program loader: assembles a big-endian byte stream into 32-bit words.
// It writes each word to imem and holds the CPU until the XOR checksum of the image is verified.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [7:0]        InByte,
    input  logic              InValid,
    output logic              InReady,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [31:0]       WrData,
    output logic              CpuHold,
    output logic              Done,
    output logic              Err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } state_t;

    localparam logic [16:0]     MAX_N   = 17'(2**ADDR_W);
    localparam logic [ADDR_W:0] WC_ONE  = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [7:0]          hdr_hi_q, hdr_hi_d;
    logic [23:0]         asm_q, asm_d;
    logic [7:0]          xor_q, xor_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]         wr_data_q, wr_data_d;

    logic                accept;
    logic [15:0]         hdr_n;
    logic [ADDR_W:0]     word_inc;

    assign InReady  = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
    assign CpuHold  = InReady || (state_q == ERR);
    assign Done     = (state_q == DONE);
    assign Err      = (state_q == ERR);
    assign WrEn     = wr_en_q;
    assign WrAddr   = wr_addr_q;
    assign WrData   = wr_data_q;

    assign accept   = InValid && InReady;
    assign hdr_n    = {hdr_hi_q, InByte};
    assign word_inc = word_cnt_q + WC_ONE;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            n_q        <= '0;
            hdr_hi_q   <= '0;
            asm_q      <= '0;
            xor_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            n_q        <= n_d;
            hdr_hi_q   <= hdr_hi_d;
            asm_q      <= asm_d;
            xor_q      <= xor_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        n_d        = n_q;
        hdr_hi_d   = hdr_hi_q;
        asm_d      = asm_q;
        xor_d      = xor_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    state_d    = HDR;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    xor_d      = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    if (byte_cnt_q == 2'd0) begin
                        hdr_hi_d   = InByte;
                        byte_cnt_d = 2'd1;
                    end else begin
                        byte_cnt_d = 2'd0;
                        n_d        = hdr_n[ADDR_W:0];
                        if (hdr_n == 16'd0 || {1'b0, hdr_n} > MAX_N) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    xor_d      = xor_q ^ InByte;
                    asm_d      = {asm_q[15:0], InByte};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    // 4th byte completes the word; the partial assembler is bypassed here
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                        wr_data_d  = {asm_q, InByte};
                        word_cnt_d = word_inc;
                        if (word_inc == n_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    state_d = (InByte == xor_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, bad checksum, header errors, gaps, reset, full-size image.
module tb_imem_loader;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] InByte = 8'h00;
    logic       InValid = 1'b0;
    logic       InReady, WrEn, CpuHold, Done, Err;
    logic [9:0] WrAddr;
    logic [31:0] WrData;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    logic [7:0] img [11] = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h29};

    imem_loader #(.ADDR_W(10)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .InByte(InByte), .InValid(InValid),
        .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .CpuHold(CpuHold), .Done(Done), .Err(Err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (WrEn === 1'b1) begin
            wa_q.push_back(WrAddr);
            wd_q.push_back(WrData);
            wc_q.push_back(cyc);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wc_q.delete();
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    // Called at a negedge; presents one byte and returns at the negedge after it is accepted.
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (InReady !== 1'b1 && t < 50) begin
            InValid = 1'b0;
            @(negedge Clk);
            t++;
        end
        if (t >= 50) begin
            total++; bad++;
            $display("FAIL send_ready InReady=%b required 1", InReady);
        end
        InByte  = b;
        InValid = 1'b1;
        @(negedge Clk);
    endtask

    task automatic send_img(input int gmax, input logic [7:0] cs, input bit mid_start);
        for (int i = 0; i < 11; i++) begin
            if (gmax > 0 && i > 0) begin
                InValid = 1'b0;
                repeat ($urandom_range(1, gmax)) @(negedge Clk);
            end
            if (mid_start && i == 5) Start = 1'b1;
            send((i == 10) ? cs : img[i]);
            Start = 1'b0;
        end
        InValid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        total++;
        if ({InReady, WrEn, CpuHold, Done, Err} !== 5'b0 || WrAddr !== 10'd0 || WrData !== 32'd0) begin
            bad++;
            $display("FAIL reset_vals rdy/wen/hold/done/err=%b addr=%h data=%h required all 0",
                     {InReady, WrEn, CpuHold, Done, Err}, WrAddr, WrData);
        end
    endtask

    task automatic test_load();
        clear_log();
        pulse_start();
        total++;
        if (InReady !== 1'b1 || CpuHold !== 1'b1) begin
            bad++;
            $display("FAIL start_hold InReady=%b CpuHold=%b required 1 1", InReady, CpuHold);
        end
        send_img(0, 8'h29, 1'b0);
        total++;
        if ({Done, Err, CpuHold, InReady} !== 4'b1000) begin
            bad++;
            $display("FAIL load_status done/err/hold/rdy=%b required 1000", {Done, Err, CpuHold, InReady});
        end
        total++;
        if (wa_q.size() != 2) begin
            bad++;
            $display("FAIL load_count writes=%0d required 2", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h24080005) begin
                bad++;
                $display("FAIL load_w0 addr=%h data=%h required 000 24080005", wa_q[0], wd_q[0]);
            end
            total++;
            if (wa_q[1] !== 10'd1 || wd_q[1] !== 32'h00000000) begin
                bad++;
                $display("FAIL load_w1 addr=%h data=%h required 001 00000000", wa_q[1], wd_q[1]);
            end
            total++;
            if (wc_q[1] - wc_q[0] != 4) begin
                bad++;
                $display("FAIL load_spacing gap=%0d required 4", wc_q[1] - wc_q[0]);
            end
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        pulse_start();
        send_img(0, 8'h28, 1'b0);
        total++;
        if ({Done, Err, CpuHold, InReady} !== 4'b0110) begin
            bad++;
            $display("FAIL csum_status done/err/hold/rdy=%b required 0110", {Done, Err, CpuHold, InReady});
        end
        total++;
        if (wa_q.size() != 2 || (wa_q.size() == 2 && (wd_q[0] !== 32'h24080005 || wa_q[1] !== 10'd1))) begin
            bad++;
            $display("FAIL csum_writes count=%0d required 2 (0:24080005, 1:0)", wa_q.size());
        end
        pulse_start();
        total++;
        if (Err !== 1'b0 || InReady !== 1'b1) begin
            bad++;
            $display("FAIL csum_restart Err=%b InReady=%b required 0 1", Err, InReady);
        end
    endtask

    // Enters with the loader already in HDR from the restart above.
    task automatic test_hdr_err();
        clear_log();
        send(8'h00);
        send(8'h00);
        InValid = 1'b0;
        total++;
        if ({Err, InReady, Done} !== 3'b100) begin
            bad++;
            $display("FAIL hdr_zero err/rdy/done=%b required 100", {Err, InReady, Done});
        end
        pulse_start();
        send(8'h04);
        send(8'h01);
        InValid = 1'b0;
        total++;
        if ({Err, InReady, Done} !== 3'b100) begin
            bad++;
            $display("FAIL hdr_big err/rdy/done=%b required 100", {Err, InReady, Done});
        end
        repeat (3) @(negedge Clk);
        total++;
        if (wa_q.size() != 0) begin
            bad++;
            $display("FAIL hdr_nowrite writes=%0d required 0", wa_q.size());
        end
    endtask

    task automatic test_gaps();
        clear_log();
        pulse_start();
        send_img(3, 8'h29, 1'b0);
        total++;
        if (Done !== 1'b1 || Err !== 1'b0) begin
            bad++;
            $display("FAIL gaps_done Done=%b Err=%b required 1 0", Done, Err);
        end
        total++;
        if (wa_q.size() != 2 || (wa_q.size() == 2 &&
            (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h24080005 || wa_q[1] !== 10'd1 || wd_q[1] !== 32'd0))) begin
            bad++;
            $display("FAIL gaps_writes count=%0d required 2 (0:24080005, 1:0)", wa_q.size());
        end
    endtask

    task automatic test_rst_mid();
        clear_log();
        pulse_start();
        for (int i = 0; i < 4; i++) send(img[i]);
        InValid = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        total++;
        if ({InReady, WrEn, CpuHold, Done, Err} !== 5'b0 || WrAddr !== 10'd0 || WrData !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid_vals rdy/wen/hold/done/err=%b addr=%h data=%h required all 0",
                     {InReady, WrEn, CpuHold, Done, Err}, WrAddr, WrData);
        end
        pulse_start();
        send_img(0, 8'h29, 1'b1);
        total++;
        if (Done !== 1'b1 || Err !== 1'b0) begin
            bad++;
            $display("FAIL rst_reload_done Done=%b Err=%b required 1 0", Done, Err);
        end
        total++;
        if (wa_q.size() != 2 || (wa_q.size() == 2 &&
            (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h24080005 || wa_q[1] !== 10'd1 || wd_q[1] !== 32'd0))) begin
            bad++;
            $display("FAIL rst_reload_writes count=%0d required 2 (0:24080005, 1:0)", wa_q.size());
        end
    endtask

    task automatic test_full();
        int nbad;
        logic [7:0] cs;
        logic [15:0] w;
        clear_log();
        cs = 8'h00;
        pulse_start();
        send(8'h04);
        send(8'h00);
        for (int i = 0; i < 1024; i++) begin
            w = 16'(i);
            send(8'h00); send(8'h00); send(w[15:8]); send(w[7:0]);
            cs = cs ^ w[15:8] ^ w[7:0];
        end
        send(cs);
        InValid = 1'b0;
        total++;
        if (Done !== 1'b1 || Err !== 1'b0 || CpuHold !== 1'b0) begin
            bad++;
            $display("FAIL full_done Done=%b Err=%b CpuHold=%b required 1 0 0", Done, Err, CpuHold);
        end
        total++;
        if (wa_q.size() != 1024) begin
            bad++;
            $display("FAIL full_count writes=%0d required 1024", wa_q.size());
        end else begin
            total++;
            if (wa_q[1023] !== 10'd1023 || wd_q[1023] !== 32'h000003FF) begin
                bad++;
                $display("FAIL full_last addr=%0d data=%h required 1023 000003ff", wa_q[1023], wd_q[1023]);
            end
            nbad = 0;
            for (int i = 0; i < 1024; i++)
                if (wa_q[i] !== 10'(i) || wd_q[i] !== 32'(i)) nbad++;
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL full_contents wrong_words=%0d required 0", nbad);
            end
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_load();
        test_bad_csum();
        test_hdr_err();
        test_gaps();
        test_rst_mid();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
